// File: rtl/seq_pkg.sv
// Shared encodings for the processor phase sequence monitors.
package seq_pkg;

  // Phase indices carried on the phase output and by the classifier
  localparam logic [1:0] PH_F = 2'd0;
  localparam logic [1:0] PH_D = 2'd1;
  localparam logic [1:0] PH_E = 2'd2;
  localparam logic [1:0] PH_I = 2'd3;

  // Monitor FSM states
  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_EXP_D = 3'd1;
  localparam logic [2:0] ST_EXP_E = 3'd2;
  localparam logic [2:0] ST_EXP_I = 3'd3;
  localparam logic [2:0] ST_EXP_F = 3'd4;

  // Fault cause codes
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ZERO  = 3'd1;
  localparam logic [2:0] ERR_MULTI = 3'd2;
  localparam logic [2:0] ERR_ORDER = 3'd3;
  localparam logic [2:0] ERR_STALL = 3'd4;

  // Strobe population class
  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } cls_e;

  // Phase a waiting state expects to see next
  function automatic logic [1:0] exp_phase(input logic [2:0] st);
    logic [1:0] ph;
    ph = PH_F;
    case (st)
      ST_EXP_D: ph = PH_D;
      ST_EXP_E: ph = PH_E;
      ST_EXP_I: ph = PH_I;
      default:  ph = PH_F;
    endcase
    return ph;
  endfunction

  // State entered after accepting a given phase
  function automatic logic [2:0] state_after(input logic [1:0] ph);
    logic [2:0] st;
    st = ST_EXP_D;
    case (ph)
      PH_F:    st = ST_EXP_D;
      PH_D:    st = ST_EXP_E;
      PH_E:    st = ST_EXP_I;
      default: st = ST_EXP_F;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/seq_cls.sv
// Combinational strobe classifier: {i,e,d,f} -> ZERO/ONE/MULTI plus phase index.
module seq_cls
  import seq_pkg::*;
(
  input  logic [3:0] strb_i,
  output cls_e       cls_o,
  output logic [1:0] ph_o
);

  // Decode population and, for a single strobe, its bit position
  always_comb begin
    cls_o = CLS_MULTI;
    ph_o  = PH_F;
    case (strb_i)
      4'b0000: cls_o = CLS_ZERO;
      4'b0001: begin cls_o = CLS_ONE; ph_o = PH_F; end
      4'b0010: begin cls_o = CLS_ONE; ph_o = PH_D; end
      4'b0100: begin cls_o = CLS_ONE; ph_o = PH_E; end
      4'b1000: begin cls_o = CLS_ONE; ph_o = PH_I; end
      default: cls_o = CLS_MULTI;
    endcase
  end

endmodule

// File: rtl/seq_mon.sv
// Phase sequence monitor: checks f->d->e->i rotation, counts instructions,
// declares lock and latches the first fault cause.
// Optional macro SEQ_MON_STALL_EN lets the accepted phase repeat for up to
// STALL_MAX extra cycles before a stall fault.
module seq_mon
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LOCK_ROT = 2
`ifdef SEQ_MON_STALL_EN
  ,
  parameter int unsigned STALL_MAX = 4
`endif
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             f,
  input  logic             d,
  input  logic             e,
  input  logic             i,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [1:0]       phase
);

  localparam int unsigned ROT_W = $clog2(LOCK_ROT + 1);
`ifdef SEQ_MON_STALL_EN
  localparam int unsigned SW = $clog2(STALL_MAX + 1);
`endif

  cls_e       cls;
  logic [1:0] cls_ph;

  logic [2:0]       state_q, state_d;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       phase_q, phase_d;
`ifdef SEQ_MON_STALL_EN
  logic [SW-1:0]    stall_q, stall_d;
`endif

  logic       fault;
  logic [2:0] fcode;
  logic       accept;

  seq_cls u_cls (
    .strb_i ({i, e, d, f}),
    .cls_o  (cls),
    .ph_o   (cls_ph)
  );

  // State and counter registers, clr has priority
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_SYNC;
      rot_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      phase_q  <= PH_F;
`ifdef SEQ_MON_STALL_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rot_q    <= rot_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      code_q   <= code_d;
      phase_q  <= phase_d;
`ifdef SEQ_MON_STALL_EN
      stall_q  <= stall_d;
`endif
    end
  end

  // Fault detection, next state, rotation accounting and sticky error
  always_comb begin
    fault    = 1'b0;
    fcode    = ERR_NONE;
    accept   = 1'b0;
    state_d  = state_q;
    rot_d    = rot_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    err_d    = err_q;
    code_d   = code_q;
    phase_d  = phase_q;
`ifdef SEQ_MON_STALL_EN
    stall_d  = stall_q;
`endif

    if (state_q == ST_SYNC) begin
      // Only multi-hot is a fault while hunting for f
      if (cls == CLS_MULTI) begin
        fault = 1'b1;
        fcode = ERR_MULTI;
      end else if (cls == CLS_ONE && cls_ph == PH_F) begin
        accept = 1'b1;
      end
    end else begin
      if (cls == CLS_MULTI) begin
        fault = 1'b1;
        fcode = ERR_MULTI;
      end else if (cls == CLS_ZERO) begin
        fault = 1'b1;
        fcode = ERR_ZERO;
      end else if (cls_ph == exp_phase(state_q)) begin
        accept = 1'b1;
      end
`ifdef SEQ_MON_STALL_EN
      else if (cls_ph == phase_q) begin
        if (stall_q < SW'(STALL_MAX)) begin
          stall_d = stall_q + SW'(1);
        end else begin
          fault = 1'b1;
          fcode = ERR_STALL;
        end
      end
`endif
      else begin
        fault = 1'b1;
        fcode = ERR_ORDER;
      end
    end

    if (fault) begin
      state_d  = ST_SYNC;
      rot_d    = '0;
      locked_d = 1'b0;
      err_d    = 1'b1;
      // First cause is kept unless a clear arrives in the same cycle
      if (!err_q || err_clr) code_d = fcode;
`ifdef SEQ_MON_STALL_EN
      stall_d  = '0;
`endif
    end else begin
      if (err_clr) begin
        err_d  = 1'b0;
        code_d = ERR_NONE;
      end
      if (accept) begin
        state_d = state_after(cls_ph);
        phase_d = cls_ph;
`ifdef SEQ_MON_STALL_EN
        stall_d = '0;
`endif
        if (cls_ph == PH_I) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (rot_q < ROT_W'(LOCK_ROT)) rot_d = rot_q + ROT_W'(1);
        end
      end
      if (rot_d == ROT_W'(LOCK_ROT)) locked_d = 1'b1;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign instr_cnt = cnt_q;
  assign phase     = phase_q;

endmodule
